dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Data-memory responder on the MA-stage load/store interface; answers dmem_* requests from the memory-access stage.
- One synchronous write port and one combinational read port, so the MA stage captures load data in the same cycle as the request.
- After reset, an internal FSM zeroes the whole array before asserting ready.
- Flags any access made while the memory is not ready.

Parameters:
- MEM_ADDR_WIDTH, 12, word-address width; depth = 2**MEM_ADDR_WIDTH words.
- MEM_DATA_WIDTH, 32, word width in bits.
- CLEAR_ON_RESET, 1, 1 = run the clear sweep after reset; 0 = go straight to READY (array contents undefined).

Ports:
- clk  in  1  single clock; all state updates on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- dmem_waddr  in  MEM_ADDR_WIDTH  write word address.
- dmem_wdata  in  MEM_DATA_WIDTH  write data.
- dmem_wen  in  1  write enable; sampled at posedge.
- dmem_raddr  in  MEM_ADDR_WIDTH  read word address.
- dmem_ren  in  1  read enable.
- dmem_rdata  out  MEM_DATA_WIDTH  read data, combinational from dmem_raddr.
- dmem_ready  out  1  high when the array is accessible.
- dmem_err  out  1  sticky flag: an access was attempted while not ready.
- err_clr  in  1  synchronous clear of dmem_err.

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous, active-low, rst_n.
- Reset values:
  - FSM = CLEAR when CLEAR_ON_RESET=1, READY when CLEAR_ON_RESET=0.
  - clear counter = 0; dmem_ready = 0 when CLEAR_ON_RESET=1, 1 when CLEAR_ON_RESET=0; dmem_err = 0.
  - Array contents are not reset by rst_n itself.
- FSM states:
  - CLEAR: each cycle writes 0 to array[clr_cnt], then clr_cnt++. When clr_cnt == DEPTH-1 is written, go to READY on the next edge. Clear takes exactly DEPTH cycles after reset release.
  - READY: normal operation. Stays in READY until rst_n is asserted.
  - dmem_ready = (state == READY), registered.
- Write:
  - In READY with dmem_wen=1, array[dmem_waddr] <= dmem_wdata at the posedge.
  - In CLEAR, dmem_wen is ignored (no array update).
- Read:
  - In READY with dmem_ren=1, dmem_rdata = array[dmem_raddr] combinationally, with zero latency.
  - dmem_ren=0 or state != READY: dmem_rdata = 0.
- Read during write, same address, same cycle: dmem_rdata returns the OLD contents. The new value is visible from the cycle after the edge. No bypass.
- Simultaneous dmem_ren and dmem_wen at different addresses: both are serviced independently.
- Error flag:
  - dmem_err sets at the posedge when (dmem_wen | dmem_ren) = 1 and state != READY.
  - err_clr=1 clears it. If set and clear happen in the same cycle, set wins.
  - Once set, dmem_err holds until err_clr or reset.
- Reset mid-operation:
  - rst_n low immediately forces dmem_ready=0 and dmem_err=0 and restarts the sweep at address 0.
  - Any write on that edge is dropped.
- Address wrap: the clear counter is MEM_ADDR_WIDTH+1 bits wide; the terminal compare uses DEPTH-1, with no wrap back to 0.
- Inputs with X or out-of-range values: addresses are full-width, so every address is legal. No bounds checks.

Test Plan:
- Reset clear, MEM_ADDR_WIDTH=4, CLEAR_ON_RESET=1:
  - Preload array with 0xDEADBEEF via backdoor, release rst_n.
  - Required: dmem_ready rises exactly 16 cycles after release.
  - Required: afterwards, every read of addresses 0..15 returns 0x00000000.
- Write-then-read:
  - wen=1, waddr=0x3, wdata=0x12345678 for one cycle.
  - Required: next cycle, ren=1, raddr=0x3 gives dmem_rdata=0x12345678 combinationally in that cycle.
- Same-address read/write collision:
  - array[5]=0x11111111.
  - Same cycle: wen=1, waddr=5, wdata=0x22222222, ren=1, raddr=5.
  - Required: rdata=0x11111111 in that cycle, 0x22222222 the following cycle.
- Access during clear:
  - wen=1, waddr=2, wdata=0xAAAA5555 in cycle 3 after reset release.
  - Required: dmem_err=1 from the next edge.
  - Required: after READY, array[2] reads 0.
  - err_clr pulse: dmem_err=0 on the following edge.
- Mid-operation reset:
  - Write 0xCAFEF00D to addr 7 in READY, then pulse rst_n low for 1 cycle.
  - Required: dmem_ready drops immediately.
  - Required: after a new 16-cycle sweep, addr 7 reads 0.
- Idle read gating:
  - In READY, ren=0 with raddr pointing at a nonzero word.
  - Required: dmem_rdata=0.
  - Required: with CLEAR_ON_RESET=0, dmem_ready=1 in the first cycle after reset release.

Source files
------------

// File: rtl/dmem_if.sv
// Load/store bus between the memory-access stage and the data memory.
// The MA stage is the master; the data-memory responder is the slave.
interface dmem_if #(
   parameter int MEM_ADDR_WIDTH = 12,
   parameter int MEM_DATA_WIDTH = 32
);
   logic [MEM_ADDR_WIDTH-1:0] dmem_waddr;
   logic [MEM_DATA_WIDTH-1:0] dmem_wdata;
   logic                      dmem_wen;
   logic [MEM_ADDR_WIDTH-1:0] dmem_raddr;
   logic                      dmem_ren;
   logic [MEM_DATA_WIDTH-1:0] dmem_rdata;
   logic                      dmem_ready;
   logic                      dmem_err;
   logic                      err_clr;

   modport master (
      output dmem_waddr, dmem_wdata, dmem_wen, dmem_raddr, dmem_ren, err_clr,
      input  dmem_rdata, dmem_ready, dmem_err
   );

   modport slave (
      input  dmem_waddr, dmem_wdata, dmem_wen, dmem_raddr, dmem_ren, err_clr,
      output dmem_rdata, dmem_ready, dmem_err
   );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder for the MA-stage load/store bus.
// One synchronous write port, one combinational (zero-latency) read port.
// After reset an internal sweep zeroes every word before the array is
// reported ready; any access attempted before that raises a sticky error.
module dmem_responder #(
   parameter int MEM_ADDR_WIDTH = 12,
   parameter int MEM_DATA_WIDTH = 32,
   parameter bit CLEAR_ON_RESET = 1'b1
) (
   input  logic  clk,
   input  logic  rst_n,
   dmem_if.slave bus
);

   localparam int DEPTH = 1 << MEM_ADDR_WIDTH;
   // One extra bit so the counter can never wrap onto address 0.
   localparam logic [MEM_ADDR_WIDTH:0] LAST_ADDR = (MEM_ADDR_WIDTH+1)'(DEPTH - 1);

   typedef enum logic {
      ST_CLEAR = 1'b0,
      ST_READY = 1'b1
   } state_t;

   state_t                    state;
   logic [MEM_ADDR_WIDTH:0]   clr_cnt;
   logic                      ready;
   logic                      err;

   logic [MEM_DATA_WIDTH-1:0] mem [DEPTH];

   logic                      mem_we;
   logic [MEM_ADDR_WIDTH-1:0] mem_wa;
   logic [MEM_DATA_WIDTH-1:0] mem_wd;
   logic                      access;

   assign access = bus.dmem_wen | bus.dmem_ren;

   // Control FSM: clear sweep, ready flag and sticky access-while-busy error.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= CLEAR_ON_RESET ? ST_CLEAR : ST_READY;
         clr_cnt <= '0;
         ready   <= !CLEAR_ON_RESET;
         err     <= 1'b0;
      end else begin
         case (state)
            ST_CLEAR: begin
               clr_cnt <= clr_cnt + 1'b1;
               if (clr_cnt == LAST_ADDR) begin
                  state <= ST_READY;
                  ready <= 1'b1;
               end
            end
            ST_READY: begin
               state <= ST_READY;
               ready <= 1'b1;
            end
            default: begin
               state <= ST_CLEAR;
               ready <= 1'b0;
            end
         endcase

         // A new violation takes priority over a clear request in the same cycle.
         if (access && (state != ST_READY)) begin
            err <= 1'b1;
         end else if (bus.err_clr) begin
            err <= 1'b0;
         end
      end
   end

   // Write-port select: the sweep owns the port while clearing, the bus otherwise.
   always_comb begin
      mem_we = 1'b0;
      mem_wa = '0;
      mem_wd = '0;
      if (state == ST_CLEAR) begin
         mem_we = 1'b1;
         mem_wa = clr_cnt[MEM_ADDR_WIDTH-1:0];
      end else if (bus.dmem_wen) begin
         mem_we = 1'b1;
         mem_wa = bus.dmem_waddr;
         mem_wd = bus.dmem_wdata;
      end
   end

   // Array write; contents survive reset, and nothing is written on an edge seen while in reset.
   always_ff @(posedge clk) begin
      if (rst_n && mem_we) begin
         mem[mem_wa] <= mem_wd;
      end
   end

   // Combinational read with no write bypass, so a same-address write shows up next cycle.
   assign bus.dmem_rdata = ((state == ST_READY) && bus.dmem_ren) ? mem[bus.dmem_raddr] : '0;
   assign bus.dmem_ready = ready;
   assign bus.dmem_err   = err;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: clear sweep timing, read/write behaviour,
// collision semantics, error flag and mid-operation reset.
module tb_dmem_responder;

   localparam int AW = 4;
   localparam int DW = 32;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   dmem_if #(.MEM_ADDR_WIDTH(AW), .MEM_DATA_WIDTH(DW)) bus ();
   dmem_if #(.MEM_ADDR_WIDTH(AW), .MEM_DATA_WIDTH(DW)) bus2 ();

   dmem_responder #(.MEM_ADDR_WIDTH(AW), .MEM_DATA_WIDTH(DW), .CLEAR_ON_RESET(1'b1)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   dmem_responder #(.MEM_ADDR_WIDTH(AW), .MEM_DATA_WIDTH(DW), .CLEAR_ON_RESET(1'b0)) dut2 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus2)
   );

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic          wen;
      logic [AW-1:0] waddr;
      logic [DW-1:0] wdata;
      logic          ren;
      logic [AW-1:0] raddr;
      logic          err_clr;
      logic [DW-1:0] exp_rdata;
      logic          exp_err;
   } vec_t;

   typedef struct {
      logic [DW-1:0] rdata;
      logic          err;
   } exp_t;

   exp_t sb[$];
   vec_t tbl_a[$];
   vec_t tbl_b[$];

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic wen, input logic [AW-1:0] waddr, input logic [DW-1:0] wdata,
                               input logic ren, input logic [AW-1:0] raddr, input logic err_clr,
                               input logic [DW-1:0] exp_rdata, input logic exp_err);
      vec_t v;
      v.wen = wen; v.waddr = waddr; v.wdata = wdata;
      v.ren = ren; v.raddr = raddr; v.err_clr = err_clr;
      v.exp_rdata = exp_rdata; v.exp_err = exp_err;
      return v;
   endfunction

   task automatic idle();
      bus.dmem_wen = 1'b0; bus.dmem_waddr = '0; bus.dmem_wdata = '0;
      bus.dmem_ren = 1'b0; bus.dmem_raddr = '0; bus.err_clr = 1'b0;
   endtask

   // Called just after a rising edge: drives one vector, checks read data
   // mid-cycle and the error/ready flags after the next edge.
   task automatic apply(input vec_t v, input string tag);
      exp_t e;
      bus.dmem_wen = v.wen; bus.dmem_waddr = v.waddr; bus.dmem_wdata = v.wdata;
      bus.dmem_ren = v.ren; bus.dmem_raddr = v.raddr; bus.err_clr = v.err_clr;
      sb.push_back('{rdata: v.exp_rdata, err: v.exp_err});
      @(negedge clk);
      e = sb.pop_front();
      chk($sformatf("%s rdata", tag), bus.dmem_rdata, e.rdata);
      @(posedge clk); #1;
      chk($sformatf("%s err", tag), {31'b0, bus.dmem_err}, {31'b0, e.err});
      chk($sformatf("%s ready", tag), {31'b0, bus.dmem_ready}, 32'd1);
   endtask

   // Walks the clear sweep cycle by cycle from reset release, optionally
   // poking the bus while the array is still busy.
   task automatic sweep(input bit with_access);
      logic          err_m;
      logic          wen, ren, clr;
      logic [AW-1:0] waddr, raddr;
      logic [DW-1:0] wdata;
      err_m = 1'b0;
      for (int k = 1; k <= 18; k++) begin
         wen = 1'b0; ren = 1'b0; clr = 1'b0; waddr = '0; raddr = '0; wdata = '0;
         if (with_access) begin
            case (k)
               3: begin wen = 1'b1; waddr = 4'd2; wdata = 32'hAAAA5555; end
               5: begin ren = 1'b1; raddr = 4'd9; clr = 1'b1; end
               7: begin clr = 1'b1; end
               8: begin wen = 1'b1; waddr = 4'd1; wdata = 32'h5A5A5A5A; end
               default: ;
            endcase
         end
         bus.dmem_wen = wen; bus.dmem_waddr = waddr; bus.dmem_wdata = wdata;
         bus.dmem_ren = ren; bus.dmem_raddr = raddr; bus.err_clr = clr;
         #1;
         chk($sformatf("sweep k=%0d rdata", k), bus.dmem_rdata, 32'h0);
         @(posedge clk); #1;
         if ((wen || ren) && (k <= 16)) err_m = 1'b1;
         else if (clr) err_m = 1'b0;
         chk($sformatf("sweep k=%0d ready", k), {31'b0, bus.dmem_ready}, (k >= 16) ? 32'd1 : 32'd0);
         chk($sformatf("sweep k=%0d err", k), {31'b0, bus.dmem_err}, {31'b0, err_m});
         if (k == 1) chk("noclear ready first cycle", {31'b0, bus2.dmem_ready}, 32'd1);
      end
      idle();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // Table A: normal operation after the first sweep.
      tbl_a.push_back(mk(1, 4'd3, 32'h12345678, 0, 4'd0, 0, 32'h0, 0));
      tbl_a.push_back(mk(0, 4'd0, 32'h0, 1, 4'd3, 0, 32'h12345678, 0));
      tbl_a.push_back(mk(1, 4'd5, 32'h11111111, 0, 4'd0, 0, 32'h0, 0));
      tbl_a.push_back(mk(1, 4'd5, 32'h22222222, 1, 4'd5, 0, 32'h11111111, 0));
      tbl_a.push_back(mk(0, 4'd0, 32'h0, 1, 4'd5, 0, 32'h22222222, 0));
      tbl_a.push_back(mk(1, 4'd9, 32'h99990000, 1, 4'd3, 0, 32'h12345678, 0));
      tbl_a.push_back(mk(0, 4'd0, 32'h0, 1, 4'd9, 0, 32'h99990000, 0));
      tbl_a.push_back(mk(0, 4'd0, 32'h0, 0, 4'd9, 0, 32'h0, 0));
      for (int i = 0; i < 16; i++)
         tbl_a.push_back(mk(1, AW'(i), 32'hDEADBEEF, 0, 4'd0, 0, 32'h0, 0));
      tbl_a.push_back(mk(0, 4'd0, 32'h0, 1, 4'd15, 0, 32'hDEADBEEF, 0));
      tbl_a.push_back(mk(0, 4'd0, 32'h0, 1, 4'd2, 0, 32'hDEADBEEF, 0));
      tbl_a.push_back(mk(1, 4'd7, 32'hCAFEF00D, 0, 4'd0, 0, 32'h0, 0));
      // Table B: after the mid-operation reset and sweep with illegal accesses.
      for (int i = 0; i < 16; i++)
         tbl_b.push_back(mk(0, 4'd0, 32'h0, 1, AW'(i), 0, 32'h0, 1));
      tbl_b.push_back(mk(0, 4'd0, 32'h0, 0, 4'd0, 1, 32'h0, 0));
      tbl_b.push_back(mk(1, 4'd4, 32'h0BADF00D, 1, 4'd7, 0, 32'h0, 0));
      tbl_b.push_back(mk(0, 4'd0, 32'h0, 1, 4'd4, 0, 32'h0BADF00D, 0));

      idle();
      bus2.dmem_wen = 1'b0; bus2.dmem_waddr = '0; bus2.dmem_wdata = '0;
      bus2.dmem_ren = 1'b0; bus2.dmem_raddr = '0; bus2.err_clr = 1'b0;

      repeat (3) @(posedge clk);
      #1;
      chk("reset ready", {31'b0, bus.dmem_ready}, 32'd0);
      chk("reset err", {31'b0, bus.dmem_err}, 32'd0);
      chk("reset rdata", bus.dmem_rdata, 32'h0);
      chk("noclear reset ready", {31'b0, bus2.dmem_ready}, 32'd1);
      rst_n = 1'b1;
      sweep(1'b0);

      foreach (tbl_a[i]) apply(tbl_a[i], $sformatf("A%0d", i));

      // Mid-operation reset: ready must drop as soon as rst_n falls.
      bus.dmem_wen = 1'b1; bus.dmem_waddr = 4'd7; bus.dmem_wdata = 32'h77777777;
      bus.dmem_ren = 1'b1; bus.dmem_raddr = 4'd7;
      #1;
      chk("pre-reset rdata", bus.dmem_rdata, 32'hCAFEF00D);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async reset ready", {31'b0, bus.dmem_ready}, 32'd0);
      chk("async reset err", {31'b0, bus.dmem_err}, 32'd0);
      chk("async reset rdata", bus.dmem_rdata, 32'h0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      sweep(1'b1);

      foreach (tbl_b[i]) apply(tbl_b[i], $sformatf("B%0d", i));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
